// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared types and constants for the sequential divider
package seq_divider_pkg;

  localparam int DATA_W   = 32;
  localparam int ITER_N   = 32;
  localparam int CNT_W    = $clog2(ITER_N);

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  function automatic logic is_signed_op(input op_e op);
    return ~op[0];
  endfunction

  function automatic logic is_rem_op(input op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - request/result bundle between a requester and the divider
interface seq_divider_if;
  import seq_divider_pkg::*;

  logic              start_i;
  logic [1:0]        op_i;
  logic [DATA_W-1:0] dividend_i;
  logic [DATA_W-1:0] divisor_i;
  logic              ready_o;
  logic              busy_o;
  logic              valid_o;
  logic [DATA_W-1:0] result_o;

  modport master (
    output start_i, op_i, dividend_i, divisor_i,
    input  ready_o, busy_o, valid_o, result_o
  );

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i,
    output ready_o, busy_o, valid_o, result_o
  );

endinterface

// File: rtl/seq_divider_restoring_step.sv
// rtl/seq_divider_restoring_step.sv - one combinational restoring-division step
module restoring_step
  import seq_divider_pkg::*;
(
  input  logic [DATA_W:0]   rem,
  input  logic              in_bit,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W:0]   next_rem,
  output logic              quotient_bit
);

  // Shifted remainder is below 2^33, so bit 33 of the difference is an exact borrow.
  logic [DATA_W+1:0] diff;

  always_comb begin
    diff         = {rem, in_bit} - {2'b00, divisor};
    quotient_bit = ~diff[DATA_W+1];
    next_rem     = quotient_bit ? diff[DATA_W:0] : {rem[DATA_W-1:0], in_bit};
  end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - fixed-latency 32-bit restoring divider for RV32M DIV/DIVU/REM/REMU
module seq_divider
  import seq_divider_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  seq_divider_if.slave bus
);

  state_e            state_q, state_d;
  op_e               op_q;
  logic [DATA_W-1:0] dividend_q, divisor_q, div_mag_q, quo_q, result_q;
  logic [DATA_W:0]   rem_q, step_rem;
  logic [CNT_W-1:0]  cnt_q;
  logic              q_neg_q, r_neg_q, div_zero_q, step_bit;
  logic              sign_a, sign_b;
  logic [DATA_W-1:0] fix_value;

  restoring_step u_step (
    .rem          (rem_q),
    .in_bit       (quo_q[DATA_W-1]),
    .divisor      (div_mag_q),
    .next_rem     (step_rem),
    .quotient_bit (step_bit)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start_i) state_d = ST_PREP;
      ST_PREP: state_d = ST_ITER;
      ST_ITER: if (cnt_q == CNT_W'(ITER_N - 1)) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.ready_o  = (state_q == ST_IDLE);
    bus.busy_o   = (state_q != ST_IDLE);
    bus.valid_o  = (state_q == ST_DONE);
    bus.result_o = result_q;
  end

  assign sign_a = is_signed_op(op_q) & dividend_q[DATA_W-1];
  assign sign_b = is_signed_op(op_q) & divisor_q[DATA_W-1];

  // Divide-by-zero bypasses sign correction; signed overflow falls out of the negate naturally.
  always_comb begin
    fix_value = '0;
    if (div_zero_q)
      fix_value = is_rem_op(op_q) ? dividend_q : '1;
    else if (is_rem_op(op_q))
      fix_value = r_neg_q ? -rem_q[DATA_W-1:0] : rem_q[DATA_W-1:0];
    else
      fix_value = q_neg_q ? -quo_q : quo_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q       <= OP_DIV;
      dividend_q <= '0;
      divisor_q  <= '0;
      div_mag_q  <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      div_zero_q <= 1'b0;
      result_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.start_i) begin
          op_q       <= op_e'(bus.op_i);
          dividend_q <= bus.dividend_i;
          divisor_q  <= bus.divisor_i;
        end
        ST_PREP: begin
          quo_q      <= sign_a ? -dividend_q : dividend_q;
          div_mag_q  <= sign_b ? -divisor_q : divisor_q;
          rem_q      <= '0;
          q_neg_q    <= sign_a ^ sign_b;
          r_neg_q    <= sign_a;
          div_zero_q <= (divisor_q == '0);
          cnt_q      <= '0;
        end
        ST_ITER: begin
          rem_q <= step_rem;
          quo_q <= {quo_q[DATA_W-2:0], step_bit};
          cnt_q <= cnt_q + 1'b1;
        end
        ST_FIX:  result_q <= fix_value;
        default: ;
      endcase
    end
  end

endmodule
